// File: rtl/mem_fill_pkg.sv
`default_nettype none
// ============================================================================
// mem_fill_pkg : shared types and constants for the memory fill arbiter
// Revision     : 1.0
// ============================================================================
package mem_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int DEF_WORDS_PER_BLOCK = 8;

    // Byte-offset bits inside a block of 16-bit words.
    function automatic logic [15:0] block_offset_mask(input int words);
        return 16'(2 * words - 1);
    endfunction

    localparam logic [15:0] BLOCK_OFFSET_MASK = block_offset_mask(DEF_WORDS_PER_BLOCK);

endpackage
`default_nettype wire

// File: rtl/mem_fill_arbiter_fill_counter.sv
`default_nettype none
// ============================================================================
// fill_counter : issue / return word counters for one block fill
// Revision     : 1.0
// ============================================================================
module fill_counter #(
    parameter  int WORDS_PER_BLOCK = 8,
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             issue_inc_i,
    input  logic             ret_inc_i,
    output logic [IDX_W-1:0] issue_cnt_o,
    output logic [IDX_W-1:0] ret_cnt_o,
    output logic             issue_last_o,
    output logic             ret_last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    logic [IDX_W-1:0] issue_cnt_q;
    logic [IDX_W-1:0] ret_cnt_q;
    logic             issue_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            issue_last_q <= 1'b0;
        end else if (clr_i) begin
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            issue_last_q <= 1'b0;
        end else begin
            if (issue_inc_i && !issue_last_q) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
                if (issue_cnt_q == LAST_IDX) begin
                    issue_last_q <= 1'b1;
                end
            end
            if (ret_inc_i) begin
                ret_cnt_q <= ret_cnt_q + 1'b1;
            end
        end
    end

    assign issue_cnt_o  = issue_cnt_q;
    assign ret_cnt_o    = ret_cnt_q;
    // issue_last_o rises once the final read of the block has gone out.
    assign issue_last_o = issue_last_q;
    assign ret_last_o   = (ret_cnt_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// mem_fill_arbiter : shares main memory between I-miss, D-miss and D-store
// Revision         : 1.0
// ============================================================================
module mem_fill_arbiter
    import mem_fill_pkg::*;
#(
    parameter  int WORDS_PER_BLOCK = 8,
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_miss,
    input  logic [15:0]      i_miss_addr,
    input  logic             d_miss,
    input  logic [15:0]      d_miss_addr,
    input  logic             d_wr_req,
    input  logic [15:0]      d_wr_addr,
    input  logic [15:0]      d_wr_data,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_data_valid,
    output logic [15:0]      fill_data,
    output logic [IDX_W-1:0] fill_word,
    output logic             i_fill_we,
    output logic             d_fill_we,
    output logic             i_fill_done,
    output logic             d_fill_done,
    output logic             d_wr_done,
    output logic             busy
);

    localparam logic [15:0] OFFSET_MASK = block_offset_mask(WORDS_PER_BLOCK);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [15:0]      base_q, base_d;

    logic             cnt_clr, issue_inc, ret_inc;
    logic             issue_last, ret_last;
    logic [IDX_W-1:0] issue_cnt, ret_cnt;

    fill_counter #(
        .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
    ) u_fill_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (cnt_clr),
        .issue_inc_i (issue_inc),
        .ret_inc_i   (ret_inc),
        .issue_cnt_o (issue_cnt),
        .ret_cnt_o   (ret_cnt),
        .issue_last_o(issue_last),
        .ret_last_o  (ret_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            wr_q    <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        base_d      = base_q;
        cnt_clr     = 1'b0;
        issue_inc   = 1'b0;
        ret_inc     = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_word   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_done   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                // Fixed priority: store, then D miss, then I miss.
                if (d_wr_req) begin
                    state_d = WRITE;
                    owner_d = OWN_D;
                    wr_d    = 1'b1;
                end else if (d_miss) begin
                    state_d = FILL;
                    owner_d = OWN_D;
                    wr_d    = 1'b0;
                    base_d  = d_miss_addr & ~OFFSET_MASK;
                end else if (i_miss) begin
                    state_d = FILL;
                    owner_d = OWN_I;
                    wr_d    = 1'b0;
                    base_d  = i_miss_addr & ~OFFSET_MASK;
                end
            end

            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
                state_d   = DONE;
            end

            FILL: begin
                if (!issue_last) begin
                    mem_en    = 1'b1;
                    issue_inc = 1'b1;
                    mem_addr  = base_q + 16'({issue_cnt, 1'b0});
                end
                // Returns may overlap the issue phase; only valid pulses count.
                fill_data = mem_rdata;
                fill_word = ret_cnt;
                if (mem_data_valid) begin
                    ret_inc   = 1'b1;
                    i_fill_we = (owner_q == OWN_I);
                    d_fill_we = (owner_q == OWN_D);
                    if (ret_last) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (wr_q) begin
                    d_wr_done = 1'b1;
                end else if (owner_q == OWN_D) begin
                    d_fill_done = 1'b1;
                end else begin
                    i_fill_done = 1'b1;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_fill_arbiter : randomized bench with a transaction-level reference
// Revision            : 1.0
// ============================================================================
module tb_mem_fill_arbiter;

    localparam int          W   = 8;
    localparam int          LAT = 4;
    localparam logic [15:0] OFS = 16'(2 * W - 1);

    logic        clk;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_data_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy;

    mem_fill_arbiter #(.WORDS_PER_BLOCK(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_miss        (i_miss),
        .i_miss_addr   (i_miss_addr),
        .d_miss        (d_miss),
        .d_miss_addr   (d_miss_addr),
        .d_wr_req      (d_wr_req),
        .d_wr_addr     (d_wr_addr),
        .d_wr_data     (d_wr_data),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_data_valid(mem_data_valid),
        .fill_data     (fill_data),
        .fill_word     (fill_word),
        .i_fill_we     (i_fill_we),
        .d_fill_we     (d_fill_we),
        .i_fill_done   (i_fill_done),
        .d_fill_done   (d_fill_done),
        .d_wr_done     (d_wr_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    // Memory: reads answered in order, LAT cycles after issue at the earliest.
    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;
    rd_t rq[$];
    bit  stall, gap_mode, idle_pulse;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (idle_pulse) begin
                mem_data_valid = 1'b1;
                mem_rdata      = 16'($urandom);
            end else if (!stall && rq.size() > 0 && rq[0].due <= cyc &&
                         (!gap_mode || $urandom_range(0, 2) != 0)) begin
                mem_data_valid = 1'b1;
                mem_rdata      = mem_word(rq[0].addr);
                void'(rq.pop_front());
            end else begin
                mem_data_valid = 1'b0;
                mem_rdata      = 16'($urandom);
            end
        end
    end

    // Reference: one transaction at a time, chosen by priority when idle.
    // phase 0 idle, 1 active, 2 completion; kind 0 store, 1 D fill, 2 I fill.
    int          m_phase = 0;
    int          m_kind  = 0;
    int          m_iss, m_ret;
    logic [15:0] m_base;
    int          done_log[$];
    int          last_done_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs",
                      {5'b0, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                       i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy}, 64'd0);
                m_phase = 0;
            end else begin
                if (mem_en && !mem_wr) rq.push_back('{mem_addr, cyc + LAT});
                case (m_phase)
                    0: begin
                        check("idle_quiet",
                              {24'b0, mem_en, mem_wr, mem_addr, mem_wdata, i_fill_we, d_fill_we,
                               i_fill_done, d_fill_done, d_wr_done, busy}, 64'd0);
                        if (d_wr_req || d_miss || i_miss) begin
                            m_phase = 1;
                            m_iss   = 0;
                            m_ret   = 0;
                            if (d_wr_req) m_kind = 0;
                            else if (d_miss) begin
                                m_kind = 1;
                                m_base = d_miss_addr & ~OFS;
                            end else begin
                                m_kind = 2;
                                m_base = i_miss_addr & ~OFS;
                            end
                        end
                    end
                    1: begin
                        check("busy_active", busy, 1);
                        check("no_early_done", {i_fill_done, d_fill_done, d_wr_done}, 0);
                        if (m_kind == 0) begin
                            check("wr_strobe", {mem_en, mem_wr, i_fill_we, d_fill_we}, 4'b1100);
                            check("wr_addr", mem_addr, d_wr_addr);
                            check("wr_data", mem_wdata, d_wr_data);
                            m_phase = 2;
                        end else begin
                            check("rd_en", {mem_en, mem_wr}, {m_iss < W, 1'b0});
                            if (m_iss < W) begin
                                check("rd_addr", mem_addr, m_base + 16'(2 * m_iss));
                                m_iss++;
                            end
                            check("fill_we", {i_fill_we, d_fill_we},
                                  {m_kind == 2 && mem_data_valid, m_kind == 1 && mem_data_valid});
                            if (mem_data_valid) begin
                                check("fill_word", fill_word, m_ret);
                                check("fill_data", fill_data, mem_word(m_base + 16'(2 * m_ret)));
                                m_ret++;
                                if (m_ret == W) m_phase = 2;
                            end
                        end
                    end
                    default: begin
                        check("done_pulse",
                              {busy, mem_en, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done},
                              {1'b1, 3'b000, m_kind == 2, m_kind == 1, m_kind == 0});
                        done_log.push_back(m_kind);
                        last_done_cyc = cyc;
                        m_phase       = 0;
                    end
                endcase
                // Requesters drop their level on seeing their done pulse.
                if (i_fill_done) i_miss = 1'b0;
                if (d_fill_done) d_miss = 1'b0;
                if (d_wr_done)   d_wr_req = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #2;
            if (!i_miss && !d_miss && !d_wr_req && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle_done", ok, 1);
        if (!ok) begin
            rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
        repeat (2) @(posedge clk);
    endtask

    function automatic int log_at(input int k);
        return (done_log.size() > k) ? done_log[k] : 99;
    endfunction

    int t0;

    initial begin
        rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        mem_rdata = '0; mem_data_valid = 1'b0;
        stall = 1'b0; gap_mode = 1'b0; idle_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Plain I fill with the nominal latency.
        done_log.delete();
        @(posedge clk); #1;
        i_miss_addr = 16'h1236; i_miss = 1'b1; t0 = cyc;
        wait_idle();
        check("i_fill_latency", last_done_cyc - t0, 13);
        check("i_fill_kind", log_at(0), 2);

        // All three at once: store, then D fill, then I fill.
        done_log.delete();
        @(posedge clk); #1;
        d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; d_miss_addr = 16'h2008; i_miss_addr = 16'h3000;
        d_wr_req = 1'b1; d_miss = 1'b1; i_miss = 1'b1;
        wait_idle();
        check("prio_count", done_log.size(), 3);
        check("prio_first", log_at(0), 0);
        check("prio_second", log_at(1), 1);
        check("prio_third", log_at(2), 2);

        // Top block of the address space.
        @(posedge clk); #1;
        i_miss_addr = 16'hFFFA; i_miss = 1'b1; t0 = cyc;
        wait_idle();
        check("top_block_latency", last_done_cyc - t0, 13);

        // Reset in cycle 7 of a D fill, then a fresh I fill.
        done_log.delete();
        @(posedge clk); #1;
        d_miss_addr = 16'h4C1E; d_miss = 1'b1;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0; d_miss = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 i_miss_addr = 16'h0A12; i_miss = 1'b1;
        wait_idle();
        check("reset_done_count", done_log.size(), 1);
        check("reset_then_i", log_at(0), 2);

        // Returns withheld for 20 cycles after the last issue.
        stall = 1'b1;
        @(posedge clk); #1;
        i_miss_addr = 16'h5550; i_miss = 1'b1; t0 = cyc;
        repeat (28) @(posedge clk);
        @(negedge clk) stall = 1'b0;
        wait_idle();
        check("stall_latency", last_done_cyc - t0, 37);

        // Stray valids while idle.
        done_log.delete();
        @(negedge clk) idle_pulse = 1'b1;
        repeat (3) @(negedge clk);
        idle_pulse = 1'b0;
        @(negedge clk);
        check("idle_pulse_busy", busy, 0);
        check("idle_pulse_done", done_log.size(), 0);

        // Random mixes, including requests arriving while busy.
        for (int it = 0; it < 30; it++) begin
            int unsigned mask;
            mask     = $urandom_range(1, 7);
            gap_mode = 1'($urandom_range(0, 1));
            d_wr_addr   = 16'($urandom); d_wr_data = 16'($urandom);
            d_miss_addr = 16'($urandom); i_miss_addr = 16'($urandom);
            @(posedge clk); #1;
            d_wr_req = mask[0]; d_miss = mask[1]; i_miss = mask[2];
            if (mask != 7 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) @(posedge clk);
                #1;
                if (!mask[2]) begin i_miss_addr = 16'($urandom); i_miss = 1'b1; end
                else if (!mask[0]) begin d_wr_addr = 16'($urandom); d_wr_req = 1'b1; end
                else begin d_miss_addr = 16'($urandom); d_miss = 1'b1; end
            end
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
